column_loader: RTL and testbench
================================

// Module: column_loader
// PURPOSE
// Upstream feeder of the LED driver controller. Reads one frame (8 mux columns) from a dual-bank pixel RAM.
// Assembles per-column 15x432-bit shift images in a back buffer and swaps them into the front (data) on SOF/EOC.
// Pulses SOF to start each frame on the drivers; consumes EOC to advance columns and overlap the next column load with display.
// PARAMETERS
// LANES        15   data lanes (one per driver pair), width of data array
// LEDS         9    LEDs per lane per column (9 x 48 = 432 bits)
// COLUMNS      8    mux columns per frame
// WORD_W       48   RAM word = one LED (3 x 16-bit RGB)
// ADDR_W       12   RAM address width; must hold 2*COLUMNS*LANES*LEDS = 2160
// RAM_LATENCY  1    ram_rdata valid this many cycles after ram_rd (1 or 2)
// PORTS
// clk          in   1          system clock
// nrst         in   1          asynchronous active-low reset
// frame_req    in   1          pulse: a complete frame is in bank frame_bank
// frame_bank   in   1          bank to read, sampled with frame_req
// busy         out  1          frame in progress (not IDLE)
// frame_done   out  1          1-cycle pulse on the EOC of the last column
// ram_rd       out  1          read strobe
// ram_addr     out  ADDR_W     read address
// ram_rdata    in   WORD_W     read data, RAM_LATENCY after ram_rd
// SOF          out  1          1-cycle start-of-frame pulse to driver controller
// EOC          in   1          end-of-column pulse from driver controller
// data         out  [431:0] [LANES-1:0]  front buffer; bit 431 shifted first
// underrun     out  1          sticky: EOC arrived before next column loaded
// underrun_clr in   1          clears underrun (wins over a same-cycle set)
// BEHAVIOUR
// - Reset: all outputs 0, data all zeros, back buffer zeros, state IDLE, pending request cleared, underrun 0.
// - frame_req pulse in any state latches req_pending and req_bank. It is consumed on entry to FILL from IDLE.
//   A second request before consumption overwrites req_bank.
// - Word address = bank*1080 + col*135 + lane*9 + led; issued lane-major, led-minor.
//   This is one sequential run of 135 addresses per column. Use counters only, no multipliers.
// - Capture: word for (lane,led) is written to back[lane][431-48*led -: 48], RAM_LATENCY cycles after its ram_rd.
//   ram_rd is high for exactly 135 consecutive cycles per column.
// - FSM:
//   IDLE: if req_pending, load col_ld=0, first=1, go to FILL.
//   FILL: issue reads for col_ld. The column completes on the cycle after the last word is captured.
//         If first: swap (data<=back), SOF=1 that cycle, first=0, col_ld=1, stay in FILL.
//         Else if eoc_pending: swap, clear eoc_pending, then apply the WAIT rules below.
//         Else go to WAIT.
//   WAIT: on EOC, swap the same cycle (data is valid the next cycle).
//         If col_ld<COLUMNS-1: col_ld++ and go to FILL. Else go to DRAIN.
//   DRAIN: last column is displaying. On EOC, pulse frame_done and go to IDLE.
//          No swap; data holds the last column.
// - EOC in FILL (not first): set underrun and eoc_pending, and keep loading.
//   The swap occurs at fill completion; the remaining columns of the frame proceed normally.
//   An EOC in IDLE is ignored.
// - Underrun set and underrun_clr in the same cycle: cleared.
// - SOF latency: 135 + RAM_LATENCY + 1 cycles after the IDLE->FILL transition.
// - Column 1 load starts the cycle after SOF.
// - Asynchronous reset mid-frame aborts everything: no SOF, no frame_done.
// TESTING
// - frame_req, bank0, RAM word=address -> SOF at cycle 137 (RAM_LATENCY=1); data[0][431:384]=0, data[14][47:0]=134.
// - EOC x8 spaced 600 cycles -> 7 swaps; after EOC #1, data[0][431:384]=135; frame_done on EOC #8; busy 0; underrun 0.
// - bank1 request -> first address issued = 1080; last address issued in the frame = 2159.
// - EOC 50 cycles after SOF -> underrun=1; swap occurs at end of the column-1 fill; underrun_clr -> 0.
// - frame_req during DRAIN -> new frame starts on the cycle after frame_done; bank taken from the latest request.
// - nrst low mid-FILL -> ram_rd, SOF, busy, data = 0; idle until the next frame_req; RAM_LATENCY=2 variant repeats test 1 (SOF at 138).

Source files
------------

// File: rtl/column_loader.sv
// Column loader: streams one frame of 8 columns from a dual-bank pixel RAM into a back buffer,
// swaps each finished column into the front (data) buffer in step with SOF/EOC from the LED driver controller.
module column_loader #(
  parameter int LANES       = 15,
  parameter int LEDS        = 9,
  parameter int COLUMNS     = 8,
  parameter int WORD_W      = 48,
  parameter int ADDR_W      = 12,
  parameter int RAM_LATENCY = 1
) (
  input  logic                                   clk,
  input  logic                                   nrst,
  input  logic                                   frame_req,
  input  logic                                   frame_bank,
  output logic                                   busy,
  output logic                                   frame_done,
  output logic                                   ram_rd,
  output logic [ADDR_W-1:0]                      ram_addr,
  input  logic [WORD_W-1:0]                      ram_rdata,
  output logic                                   SOF,
  input  logic                                   EOC,
  output logic [LANES-1:0][LEDS*WORD_W-1:0]      data,
  output logic                                   underrun,
  input  logic                                   underrun_clr
);

  localparam int COL_W  = LEDS * WORD_W;
  localparam int LANE_W = $clog2(LANES);
  localparam int LED_W  = $clog2(LEDS);
  localparam int CIDX_W = $clog2(COLUMNS);
  localparam logic [ADDR_W-1:0] BANK_BASE = ADDR_W'(COLUMNS * LANES * LEDS);

  typedef enum logic [1:0] {IDLE, FILL, WAIT, DRAIN} state_t;

  // One entry per outstanding read: where its word lands once the RAM returns it.
  typedef struct packed {
    logic              vld;
    logic              last;
    logic [LANE_W-1:0] lane;
    logic [LED_W-1:0]  led;
  } cap_t;

  typedef logic [LANES-1:0][COL_W-1:0] img_t;

  state_t              state_q, state_d;
  logic                req_pending_q, req_pending_d;
  logic                req_bank_q, req_bank_d;
  logic [CIDX_W-1:0]   col_ld_q, col_ld_d;
  logic                first_q, first_d;
  logic                eoc_pending_q, eoc_pending_d;
  logic                underrun_q, underrun_d;
  logic                sof_q, sof_d;
  logic                frame_done_q, frame_done_d;
  logic                busy_q, busy_d;
  logic                ram_rd_q, ram_rd_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [LED_W-1:0]    led_q, led_d;
  logic                start_q, start_d;
  logic                fill_done_q, fill_done_d;
  cap_t [RAM_LATENCY-1:0] cap_q, cap_d;
  img_t                back_q, back_d;
  img_t                front_q, front_d;

  logic issue_last;
  logic swap;
  logic advance;
  logic underrun_set;
  cap_t cap_out;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    req_pending_d = req_pending_q;
    req_bank_d    = req_bank_q;
    col_ld_d      = col_ld_q;
    first_d       = first_q;
    eoc_pending_d = eoc_pending_q;
    sof_d         = 1'b0;
    frame_done_d  = 1'b0;
    ram_rd_d      = ram_rd_q;
    ram_addr_d    = ram_addr_q;
    lane_d        = lane_q;
    led_d         = led_q;
    start_d       = start_q;
    fill_done_d   = fill_done_q;
    back_d        = back_q;
    front_d       = front_q;
    swap          = 1'b0;
    advance       = 1'b0;
    underrun_set  = 1'b0;

    // Read issue: one sequential run of LANES*LEDS addresses, lane-major / led-minor.
    issue_last = (lane_q == LANE_W'(LANES - 1)) && (led_q == LED_W'(LEDS - 1));
    if (ram_rd_q) begin
      if (issue_last) begin
        ram_rd_d = 1'b0;
      end else begin
        ram_addr_d = ram_addr_q + 1'b1;
        if (led_q == LED_W'(LEDS - 1)) begin
          led_d  = '0;
          lane_d = lane_q + 1'b1;
        end else begin
          led_d = led_q + 1'b1;
        end
      end
    end
    if (start_q) begin
      start_d    = 1'b0;
      ram_rd_d   = 1'b1;
      ram_addr_d = ram_addr_q + 1'b1;
      lane_d     = '0;
      led_d      = '0;
    end

    cap_d[0] = '{vld: ram_rd_q, last: ram_rd_q && issue_last, lane: lane_q, led: led_q};
    for (int i = 1; i < RAM_LATENCY; i++) cap_d[i] = cap_q[i-1];
    cap_out = cap_q[RAM_LATENCY-1];
    if (cap_out.vld) begin
      back_d[cap_out.lane][(LEDS - 1 - int'(cap_out.led)) * WORD_W +: WORD_W] = ram_rdata;
    end
    if (cap_out.vld && cap_out.last) fill_done_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (req_pending_q) begin
          req_pending_d = 1'b0;
          state_d       = FILL;
          col_ld_d      = '0;
          first_d       = 1'b1;
          eoc_pending_d = 1'b0;
          ram_rd_d      = 1'b1;
          ram_addr_d    = req_bank_q ? BANK_BASE : '0;
          lane_d        = '0;
          led_d         = '0;
        end
      end
      FILL: begin
        if (fill_done_q) begin
          fill_done_d = 1'b0;
          if (first_q) begin
            swap     = 1'b1;
            sof_d    = 1'b1;
            first_d  = 1'b0;
            col_ld_d = CIDX_W'(1);
            start_d  = 1'b1;
          end else if (eoc_pending_q || EOC) begin
            // An EOC landing exactly on completion finds the column ready: no underrun.
            swap          = 1'b1;
            eoc_pending_d = 1'b0;
            advance       = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end else if (EOC && !first_q) begin
          underrun_set  = 1'b1;
          eoc_pending_d = 1'b1;
        end
      end
      WAIT: begin
        if (EOC) begin
          swap    = 1'b1;
          advance = 1'b1;
        end
      end
      DRAIN: begin
        if (EOC) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (col_ld_q != CIDX_W'(COLUMNS - 1)) begin
        col_ld_d = col_ld_q + 1'b1;
        start_d  = 1'b1;
        state_d  = FILL;
      end else begin
        state_d = DRAIN;
      end
    end
    if (swap) front_d = back_q;

    // A request is latched after consumption so one arriving on the IDLE->FILL edge is kept.
    if (frame_req) begin
      req_pending_d = 1'b1;
      req_bank_d    = frame_bank;
    end

    underrun_d = underrun_q | underrun_set;
    if (underrun_clr) underrun_d = 1'b0;
    busy_d = (state_d != IDLE);
  end

  // NOTE: non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= IDLE;
      req_pending_q <= 1'b0;
      req_bank_q    <= 1'b0;
      col_ld_q      <= '0;
      first_q       <= 1'b0;
      eoc_pending_q <= 1'b0;
      underrun_q    <= 1'b0;
      sof_q         <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
      ram_rd_q      <= 1'b0;
      ram_addr_q    <= '0;
      lane_q        <= '0;
      led_q         <= '0;
      start_q       <= 1'b0;
      fill_done_q   <= 1'b0;
      cap_q         <= '0;
      // NOTE: both image buffers are flop arrays that must read as zero after reset, so they are reset too.
      back_q        <= '0;
      front_q       <= '0;
    end else begin
      state_q       <= state_d;
      req_pending_q <= req_pending_d;
      req_bank_q    <= req_bank_d;
      col_ld_q      <= col_ld_d;
      first_q       <= first_d;
      eoc_pending_q <= eoc_pending_d;
      underrun_q    <= underrun_d;
      sof_q         <= sof_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
      ram_rd_q      <= ram_rd_d;
      ram_addr_q    <= ram_addr_d;
      lane_q        <= lane_d;
      led_q         <= led_d;
      start_q       <= start_d;
      fill_done_q   <= fill_done_d;
      cap_q         <= cap_d;
      back_q        <= back_d;
      front_q       <= front_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign ram_rd     = ram_rd_q;
  assign ram_addr   = ram_addr_q;
  assign SOF        = sof_q;
  assign data       = front_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_column_loader.sv
// Self-checking bench for column_loader: RAM model, per-column image model built from the address rule,
// randomized RAM contents, latency-1 and latency-2 instances.
module tb_column_loader;

  localparam int LANES   = 15;
  localparam int LEDS    = 9;
  localparam int COLUMNS = 8;
  localparam int WORD_W  = 48;
  localparam int ADDR_W  = 12;
  localparam int COL_WORDS  = LANES * LEDS;
  localparam int BANK_WORDS = COLUMNS * COL_WORDS;
  localparam int NWORDS     = 2 * BANK_WORDS;
  localparam int COL_W      = LEDS * WORD_W;

  typedef logic [LANES-1:0][COL_W-1:0] img_t;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic              frame_req = 1'b0, frame_bank = 1'b0, EOC = 1'b0, underrun_clr = 1'b0;
  logic              busy, frame_done, ram_rd, SOF, underrun;
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_rdata = '0;
  img_t              data;

  logic              frame_req2 = 1'b0, frame_bank2 = 1'b0, EOC2 = 1'b0, underrun_clr2 = 1'b0;
  logic              busy2, frame_done2, ram_rd2, SOF2, underrun2;
  logic [ADDR_W-1:0] ram_addr2;
  logic [WORD_W-1:0] ram_rdata2 = '0, r2_stage = '0;
  img_t              data2;

  column_loader #(.RAM_LATENCY(1)) dut (
    .clk(clk), .nrst(nrst), .frame_req(frame_req), .frame_bank(frame_bank),
    .busy(busy), .frame_done(frame_done), .ram_rd(ram_rd), .ram_addr(ram_addr),
    .ram_rdata(ram_rdata), .SOF(SOF), .EOC(EOC), .data(data),
    .underrun(underrun), .underrun_clr(underrun_clr)
  );

  column_loader #(.RAM_LATENCY(2)) dut2 (
    .clk(clk), .nrst(nrst), .frame_req(frame_req2), .frame_bank(frame_bank2),
    .busy(busy2), .frame_done(frame_done2), .ram_rd(ram_rd2), .ram_addr(ram_addr2),
    .ram_rdata(ram_rdata2), .SOF(SOF2), .EOC(EOC2), .data(data2),
    .underrun(underrun2), .underrun_clr(underrun_clr2)
  );

  logic [WORD_W-1:0] mem [NWORDS];

  function automatic logic [WORD_W-1:0] rd_mem(input logic [ADDR_W-1:0] a);
    return (int'(a) < NWORDS) ? mem[a] : '0;
  endfunction

  always @(posedge clk) begin
    if (ram_rd) ram_rdata <= rd_mem(ram_addr);
    r2_stage   <= ram_rd2 ? rd_mem(ram_addr2) : '0;
    ram_rdata2 <= r2_stage;
  end

  longint cycle_cnt = 0;
  int     sof_cnt = 0, fd_cnt = 0, run = 0;
  int     rd_log[$];
  int     runs[$];
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;
  always @(negedge clk) begin
    if (SOF) sof_cnt <= sof_cnt + 1;
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (!nrst) run <= 0;
    else if (ram_rd) begin
      rd_log.push_back(int'(ram_addr));
      run <= run + 1;
    end else if (run > 0) begin
      runs.push_back(run);
      run <= 0;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected front image for column c of bank b, straight from the address/placement rule.
  function automatic img_t exp_col(input int b, input int c);
    img_t img = '0;
    for (int lane = 0; lane < LANES; lane++)
      for (int led = 0; led < LEDS; led++)
        img[lane][(LEDS-1-led)*WORD_W +: WORD_W] = mem[b*BANK_WORDS + c*COL_WORDS + lane*LEDS + led];
    return img;
  endfunction

  function automatic int img_diff(input img_t a, input img_t b);
    int n = 0;
    for (int lane = 0; lane < LANES; lane++)
      for (int w = 0; w < LEDS; w++)
        if (a[lane][w*WORD_W +: WORD_W] !== b[lane][w*WORD_W +: WORD_W]) n++;
    return n;
  endfunction

  task automatic fill_mem(input bit ramp);
    logic [63:0] r;
    for (int i = 0; i < NWORDS; i++) begin
      r = {$urandom(), $urandom()};
      mem[i] = ramp ? WORD_W'(i) : r[WORD_W-1:0];
    end
  endtask

  task automatic pulse_req(input bit bank);
    frame_bank = bank;
    frame_req  = 1'b1;
    @(negedge clk);
    frame_req  = 1'b0;
  endtask

  task automatic pulse_eoc();
    EOC = 1'b1;
    @(negedge clk);
    EOC = 1'b0;
  endtask

  // Cycles from the first ram_rd of the frame to SOF; -1 if either never shows.
  task automatic wait_sof(input bit which, output int lat);
    int t0 = -1;
    int n = 0;
    lat = -1;
    while (n < 1000) begin
      @(negedge clk);
      if ((which ? ram_rd2 : ram_rd) && t0 < 0) t0 = n;
      if (which ? SOF2 : SOF) begin
        if (t0 >= 0) lat = n - t0;
        break;
      end
      n++;
    end
  endtask

  task automatic wait_image(input img_t e, output bit found);
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (img_diff(data, e) == 0) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_frame(input bit bank, input int spacing, input bit spot);
    int lat;
    int bad;
    rd_log.delete();
    runs.delete();
    pulse_req(bank);
    wait_sof(1'b0, lat);
    check("sof_latency", lat, 137);
    check("col0_image", img_diff(data, exp_col(bank, 0)), 0);
    if (spot) begin
      check("col0_first_word", data[0][431:384], 0);
      check("col0_last_word", data[14][47:0], 134);
      check("busy_in_frame", busy, 1);
      @(negedge clk);
      check("sof_width", SOF, 0);
      check("col1_load_start", ram_rd, 1);
    end
    for (int i = 1; i <= COLUMNS; i++) begin
      repeat (spacing) @(negedge clk);
      pulse_eoc();
      if (i < COLUMNS) begin
        check("swap_image", img_diff(data, exp_col(bank, i)), 0);
        if (spot && i == 1) check("col1_first_word", data[0][431:384], 135);
      end else begin
        check("frame_done", frame_done, 1);
        check("busy_after_done", busy, 0);
        check("drain_holds_last", img_diff(data, exp_col(bank, COLUMNS-1)), 0);
      end
    end
    @(negedge clk);
    check("frame_done_width", frame_done, 0);
    check("underrun_clean", underrun, 0);
    check("rd_count", rd_log.size(), BANK_WORDS);
    if (rd_log.size() > 0) begin
      check("first_addr", rd_log[0], bank*BANK_WORDS);
      check("last_addr", rd_log[$], bank*BANK_WORDS + BANK_WORDS - 1);
    end
    bad = 0;
    foreach (rd_log[k]) if (rd_log[k] != bank*BANK_WORDS + k) bad++;
    check("addr_sequence", bad, 0);
    bad = 0;
    foreach (runs[k]) if (runs[k] != COL_WORDS) bad++;
    check("rd_run_count", runs.size(), COLUMNS);
    check("rd_run_length", bad, 0);
  endtask

  initial begin
    int     lat;
    bit     found;
    longint s_cyc;
    int     sc, fc;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_sof", SOF, 0);
    check("rst_ram_rd", ram_rd, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_underrun", underrun, 0);
    check("rst_data", img_diff(data, '0), 0);
    nrst = 1'b1;
    repeat (3) @(negedge clk);

    fill_mem(1'b1);
    do_frame(1'b0, 600, 1'b1);
    fill_mem(1'b0);
    do_frame(1'b1, 200, 1'b0);

    // Early EOC during the column-1 load.
    fill_mem(1'b0);
    pulse_req(1'b0);
    wait_sof(1'b0, lat);
    check("ur_sof_latency", lat, 137);
    s_cyc = cycle_cnt;
    repeat (49) @(negedge clk);
    pulse_eoc();
    check("underrun_set", underrun, 1);
    check("no_early_swap", img_diff(data, exp_col(0, 0)), 0);
    wait_image(exp_col(0, 1), found);
    check("ur_swap_seen", found, 1);
    check("ur_swap_cycle", cycle_cnt - s_cyc, 138);
    check("underrun_sticky", underrun, 1);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    check("underrun_cleared", underrun, 0);
    repeat (20) @(negedge clk);
    EOC = 1'b1;
    underrun_clr = 1'b1;
    @(negedge clk);
    EOC = 1'b0;
    underrun_clr = 1'b0;
    check("clr_wins_over_set", underrun, 0);
    wait_image(exp_col(0, 2), found);
    check("ur_col2_swap", found, 1);
    for (int i = 3; i < COLUMNS; i++) begin
      repeat (300) @(negedge clk);
      pulse_eoc();
      check("ur_swap_image", img_diff(data, exp_col(0, i)), 0);
    end
    repeat (300) @(negedge clk);
    pulse_eoc();
    check("ur_frame_done", frame_done, 1);

    // Requests during DRAIN: the latest bank wins and the next frame starts right after frame_done.
    fill_mem(1'b0);
    pulse_req(1'b0);
    wait_sof(1'b0, lat);
    for (int i = 1; i < COLUMNS; i++) begin
      repeat (200) @(negedge clk);
      pulse_eoc();
      check("dr_swap_image", img_diff(data, exp_col(0, i)), 0);
    end
    pulse_req(1'b0);
    repeat (3) @(negedge clk);
    pulse_req(1'b1);
    repeat (5) @(negedge clk);
    pulse_eoc();
    check("dr_frame_done", frame_done, 1);
    @(negedge clk);
    check("restart_rd", ram_rd, 1);
    check("restart_bank_addr", ram_addr, BANK_WORDS);

    // Asynchronous reset in the middle of the column-0 load.
    repeat (50) @(negedge clk);
    nrst = 1'b0;
    #1;
    check("abort_ram_rd", ram_rd, 0);
    check("abort_sof", SOF, 0);
    check("abort_busy", busy, 0);
    check("abort_data", img_diff(data, '0), 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    rd_log.delete();
    sc = sof_cnt;
    fc = fd_cnt;
    repeat (300) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_no_reads", rd_log.size(), 0);
    check("idle_no_sof", sof_cnt - sc, 0);
    check("idle_no_done", fd_cnt - fc, 0);

    fill_mem(1'b0);
    do_frame(1'b0, 150, 1'b0);

    // Latency-2 instance repeats the first frame start.
    fill_mem(1'b1);
    frame_bank2 = 1'b0;
    frame_req2  = 1'b1;
    @(negedge clk);
    frame_req2  = 1'b0;
    wait_sof(1'b1, lat);
    check("l2_sof_latency", lat, 138);
    check("l2_first_word", data2[0][431:384], 0);
    check("l2_last_word", data2[14][47:0], 134);
    check("l2_col0_image", img_diff(data2, exp_col(0, 0)), 0);
    check("l2_busy", busy2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "bench timeout");
  end

endmodule
